// File: rtl/full_adder_using_half_adders.sv
// -----------------------------------------------------------------------------
// full_adder_using_half_adders
//
// Registered ripple-carry adder of WIDTH bits. Each bit cell is built from two
// half-adder leaves and an OR gate for the carry. The result
// {Cout, Sum} = A + B + Cin is captured on the rising edge of clk whenever
// in_valid is high. It has exactly one cycle of latency and no backpressure.
//
// Parameters:
//   WIDTH      operand width in bits, 1..64 (WIDTH=1 is the classic full adder)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset (priority over capture)
//   in_valid   in   1      A/B/Cin are sampled on this edge
//   A          in   WIDTH  operand A, unsigned
//   B          in   WIDTH  operand B, unsigned
//   Cin        in   1      carry into bit 0
//   Sum        out  WIDTH  registered sum bits, held while in_valid=0
//   Cout       out  1      registered carry out of bit WIDTH-1, held while in_valid=0
//   out_valid  out  1      high when Sum/Cout were captured on the previous edge
//
// Optional build macro FA_HA_DEBUG_EN adds three registered WIDTH-bit outputs
// that are captured under the same rules as Sum:
//   dbg_ha1_carry    first half-adder carry of every bit
//   dbg_ha2_carry    second half-adder carry of every bit
//   dbg_carry_chain  ripple carries carry[WIDTH:1]
// -----------------------------------------------------------------------------

// Half-adder leaf: s = x ^ y, c = x & y.
module full_adder_using_half_adders_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module full_adder_using_half_adders #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
`ifdef FA_HA_DEBUG_EN
    ,
    output logic [WIDTH-1:0] dbg_ha1_carry,
    output logic [WIDTH-1:0] dbg_ha2_carry,
    output logic [WIDTH-1:0] dbg_carry_chain
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("full_adder_using_half_adders: WIDTH must be in 1..64");
        end
    endgenerate

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_c1;
    logic [WIDTH-1:0] w_c2;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    assign w_carry[0] = Cin;

    // The two half adders per bit stay as separate instances so that the
    // intermediate carries remain observable and are not merged into an XOR3.
    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
            full_adder_using_half_adders_ha u_ha1 (
                .i_x (A[gi]),
                .i_y (B[gi]),
                .o_s (w_s1[gi]),
                .o_c (w_c1[gi])
            );

            full_adder_using_half_adders_ha u_ha2 (
                .i_x (w_s1[gi]),
                .i_y (w_carry[gi]),
                .o_s (w_sum[gi]),
                .o_c (w_c2[gi])
            );

            assign w_carry[gi+1] = w_c1[gi] | w_c2[gi];
        end
    endgenerate

    // Inputs are only looked at when in_valid is high, so unknowns on an idle
    // bus cannot reach the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign out_valid = r_out_valid;

`ifdef FA_HA_DEBUG_EN
    logic [WIDTH-1:0] r_dbg_ha1_carry;
    logic [WIDTH-1:0] r_dbg_ha2_carry;
    logic [WIDTH-1:0] r_dbg_carry_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_ha1_carry   <= '0;
            r_dbg_ha2_carry   <= '0;
            r_dbg_carry_chain <= '0;
        end else if (in_valid) begin
            r_dbg_ha1_carry   <= w_c1;
            r_dbg_ha2_carry   <= w_c2;
            r_dbg_carry_chain <= w_carry[WIDTH:1];
        end
    end

    assign dbg_ha1_carry   = r_dbg_ha1_carry;
    assign dbg_ha2_carry   = r_dbg_ha2_carry;
    assign dbg_carry_chain = r_dbg_carry_chain;
`endif

endmodule

// File: tb/tb_full_adder_using_half_adders.sv
// -----------------------------------------------------------------------------
// tb_full_adder_using_half_adders
//
// Self-checking bench for full_adder_using_half_adders. Three instances are
// exercised side by side: WIDTH=1, WIDTH=4 and WIDTH=8. Expected results are
// queued when stimulus is driven and popped after the capturing edge.
// Build with FA_HA_DEBUG_EN defined to also check the debug outputs.
// -----------------------------------------------------------------------------
module tb_full_adder_using_half_adders;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       sum1, cout1, ov1;
    // WIDTH=4 instance
    logic       v4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] sum4;
    logic       cout4, ov4;
    // WIDTH=8 instance
    logic       v8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] sum8;
    logic       cout8, ov8;

`ifdef FA_HA_DEBUG_EN
    logic [3:0] dbg_c1_4, dbg_c2_4, dbg_ch_4;
    logic       dbg_unused1_c1, dbg_unused1_c2, dbg_unused1_ch;
    logic [7:0] dbg_c1_8, dbg_c2_8, dbg_ch_8;
`endif

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [8:0] q8[$];

    full_adder_using_half_adders #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .in_valid (v1),
        .A (a1), .B (b1), .Cin (cin1),
        .Sum (sum1), .Cout (cout1), .out_valid (ov1)
`ifdef FA_HA_DEBUG_EN
        , .dbg_ha1_carry (dbg_unused1_c1), .dbg_ha2_carry (dbg_unused1_c2),
        .dbg_carry_chain (dbg_unused1_ch)
`endif
    );

    full_adder_using_half_adders #(.WIDTH(4)) u_dut4 (
        .clk (clk), .rst (rst), .in_valid (v4),
        .A (a4), .B (b4), .Cin (cin4),
        .Sum (sum4), .Cout (cout4), .out_valid (ov4)
`ifdef FA_HA_DEBUG_EN
        , .dbg_ha1_carry (dbg_c1_4), .dbg_ha2_carry (dbg_c2_4),
        .dbg_carry_chain (dbg_ch_4)
`endif
    );

    full_adder_using_half_adders #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst), .in_valid (v8),
        .A (a8), .B (b8), .Cin (cin8),
        .Sum (sum8), .Cout (cout8), .out_valid (ov8)
`ifdef FA_HA_DEBUG_EN
        , .dbg_ha1_carry (dbg_c1_8), .dbg_ha2_carry (dbg_c2_8),
        .dbg_carry_chain (dbg_ch_8)
`endif
    );

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        v4 = 1'b1; a4 = 4'd1; b4 = 4'd1; cin4 = 1'b1;
        v8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({cout1, sum1, ov1} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_w1 cycle %0d: got cout/sum/ov=%b expected 000", i, {cout1, sum1, ov1});
            end
            tests_run++;
            if ({cout4, sum4, ov4} !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_w4 cycle %0d: got cout/sum/ov=%b expected 000000", i, {cout4, sum4, ov4});
            end
            tests_run++;
            if ({cout8, sum8, ov8} !== 10'b0) begin
                tests_failed++;
                $display("FAIL reset_w8 cycle %0d: got cout/sum/ov=%b expected 0", i, {cout8, sum8, ov8});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({cout1, sum1, ov1} !== 3'b111) begin
            tests_failed++;
            $display("FAIL release_w1: got cout/sum/ov=%b expected 111", {cout1, sum1, ov1});
        end
        tests_run++;
        if ({cout4, sum4, ov4} !== {5'd3, 1'b1}) begin
            tests_failed++;
            $display("FAIL release_w4: got cout/sum/ov=%b expected 000111", {cout4, sum4, ov4});
        end
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
    endtask

    task automatic test_truth_table();
        // {Sum, Cout} for {A,B,Cin} = 000 .. 111
        logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
        logic [1:0] exp_sc;
        logic [1:0] got;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            a1 = (i & 4) != 0;
            b1 = (i & 2) != 0;
            cin1 = (i & 1) != 0;
            exp_sc = tt[i];
            q1.push_back({exp_sc[0], exp_sc[1]});
            @(posedge clk); #1;
            tests_run++;
            got = (q1.size() != 0) ? q1.pop_front() : 2'bxx;
            if ({cout1, sum1} !== got || ov1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL truth_table abc=%0d: got cout/sum=%b ov=%b expected %b ov=1", i, {cout1, sum1}, ov1, got);
            end
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({cout1, sum1, ov1} !== 3'b011) begin
            tests_failed++;
            $display("FAIL hold_capture: got cout/sum/ov=%b expected 011", {cout1, sum1, ov1});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
            @(posedge clk); #1;
            tests_run++;
            if ({cout1, sum1, ov1} !== 3'b010) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got cout/sum/ov=%b expected 010", i, {cout1, sum1, ov1});
            end
        end
    endtask

    task automatic test_ripple_w4();
        logic [3:0] va [3] = '{4'hF, 4'hF, 4'h5};
        logic [3:0] vb [3] = '{4'h0, 4'hF, 4'hA};
        logic       vc [3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0] ve [3] = '{{1'b1, 4'h0}, {1'b1, 4'hF}, {1'b0, 4'hF}};
        logic [4:0] got;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            v4 = 1'b1; a4 = va[i]; b4 = vb[i]; cin4 = vc[i];
            q4.push_back(ve[i]);
            @(posedge clk); #1;
            tests_run++;
            got = (q4.size() != 0) ? q4.pop_front() : 5'bx;
            if ({cout4, sum4} !== got || ov4 !== 1'b1) begin
                tests_failed++;
                $display("FAIL ripple_w4 vec%0d: got cout/sum=%h ov=%b expected %h ov=1", i, {cout4, sum4}, ov4, got);
            end
        end
        @(negedge clk);
        v4 = 1'b0;
    endtask

    task automatic test_random_w8();
        logic [8:0] hold_exp = '0;
        logic [8:0] exp_v;
        logic [8:0] got;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v8   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom_range(0, 1));
            if (v8) begin
                exp_v = 9'(a8) + 9'(b8) + 9'(cin8);
                q8.push_back(exp_v);
                hold_exp = exp_v;
            end
            @(posedge clk); #1;
            tests_run++;
            if (v8) begin
                got = (q8.size() != 0) ? q8.pop_front() : 9'bx;
                if ({cout8, sum8} !== got || ov8 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL random_w8 valid #%0d: got cout/sum=%h ov=%b expected %h ov=1", i, {cout8, sum8}, ov8, got);
                end
            end else begin
                if ({cout8, sum8} !== hold_exp || ov8 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL random_w8 hold #%0d: got cout/sum=%h ov=%b expected %h ov=0", i, {cout8, sum8}, ov8, hold_exp);
                end
            end
        end
        @(negedge clk);
        v8 = 1'b0;
    endtask

`ifdef FA_HA_DEBUG_EN
    task automatic test_debug_w4();
        @(negedge clk);
        v4 = 1'b1; a4 = 4'h3; b4 = 4'h1; cin4 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({dbg_c1_4, dbg_c2_4, dbg_ch_4} !== 12'h123) begin
            tests_failed++;
            $display("FAIL debug_w4: got c1/c2/chain=%h expected 123", {dbg_c1_4, dbg_c2_4, dbg_ch_4});
        end
        tests_run++;
        if ({cout4, sum4} !== 5'h04) begin
            tests_failed++;
            $display("FAIL debug_w4_sum: got cout/sum=%h expected 04", {cout4, sum4});
        end
        @(negedge clk);
        v4 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_ripple_w4();
        test_random_w8();
`ifdef FA_HA_DEBUG_EN
        test_debug_w4();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/full_adder_using_half_adders.md
Name: full_adder_using_half_adders

Overview:
- Registered full adder. Each bit cell is built from two half adders plus an OR gate for the carry. Cells are chained as a ripple-carry adder, WIDTH bits wide.
- Used as the basic arithmetic leaf in the combinational-circuits library.
- WIDTH=1 gives the classic single-bit full adder: A + B + Cin → Sum, Cout.
- Results are captured in output registers on the clock, with a simple valid qualifier.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  high = A/B/Cin are sampled this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry into bit 0
- Sum  output  WIDTH  registered sum bits
- Cout  output  1  registered carry out of bit WIDTH-1
- out_valid  output  1  registered; high when Sum/Cout hold a result captured on the previous edge

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Half adder: s = x ^ y, c = x & y. Implement it as a separate leaf; instantiate it twice per bit, never flattened into a single XOR3.
- Bit cell i:
  - HA1(A[i], B[i]) → s1, c1
  - HA2(s1, carry[i]) → Sum_n[i], c2
  - carry[i+1] = c1 | c2
  - carry[0] = Cin
  - Cout_n = carry[WIDTH]
- The arithmetic is exact: {Cout_n, Sum_n} = A + B + Cin, computed at WIDTH+1 bits, with no truncation.
- Latency: exactly 1 cycle.
  - If in_valid=1 at rising edge N, Sum/Cout update to that result at edge N.
  - out_valid=1 after edge N.
- If in_valid=0 at an edge:
  - Sum and Cout hold their previous values.
  - out_valid goes to 0.
- Back-to-back valid inputs: a new result every cycle. There is no backpressure and no ready signal.
- Reset: when rst=1 at an edge, Sum=0, Cout=0 and out_valid=0, regardless of in_valid. Reset has priority over capture.
- Reset mid-stream: an input presented in the same cycle as rst is discarded. The first capture occurs on the first edge with rst=0 and in_valid=1.
- Wrap-around: all-ones + all-ones + 1 gives Sum = all-ones, Cout=1. All-ones + 0 + 1 gives Sum=0, Cout=1.
- X/Z on inputs while in_valid=0 must not propagate into Sum/Cout.
- No internal state other than the output registers (and the optional debug registers below).

Optional Feature:
- Macro FA_HA_DEBUG_EN.
- When defined, add three registered outputs, each WIDTH bits and captured under the same in_valid/rst rules as Sum:
  - dbg_ha1_carry: c1 of every bit
  - dbg_ha2_carry: c2 of every bit
  - dbg_carry_chain: carry[WIDTH:1]
- Debug registers reset to 0.
- When the macro is undefined, these ports and registers do not exist. Sum/Cout/out_valid behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=1, B=1, Cin=1 → Sum=0, Cout=0, out_valid=0 throughout. Release rst → next edge gives Sum=1, Cout=1.
- WIDTH=1 truth table, applying all 8 (A,B,Cin) combinations in order 000..111, one per cycle with in_valid=1. Expected (Sum,Cout) one cycle later:
  - 000 → 00, 001 → 10, 010 → 10, 011 → 01
  - 100 → 10, 101 → 01, 110 → 01, 111 → 11
  - out_valid stays 1 for all 8 cycles.
- Hold: capture A=1, B=0, Cin=0 (Sum=1, Cout=0), then drive in_valid=0 with A=1, B=1, Cin=1 for 3 cycles → Sum=1, Cout=0 held, out_valid=0.
- WIDTH=4 carry ripple:
  - A=4'hF, B=4'h0, Cin=1 → Sum=4'h0, Cout=1
  - A=4'hF, B=4'hF, Cin=1 → Sum=4'hF, Cout=1
  - A=4'h5, B=4'hA, Cin=0 → Sum=4'hF, Cout=0
- Random WIDTH=8: 1000 random A/B/Cin vectors with random in_valid → every valid result matches A+B+Cin (9-bit) one cycle later; outputs hold on invalid cycles.
- FA_HA_DEBUG_EN, WIDTH=4: A=4'h3, B=4'h1, Cin=0 → dbg_ha1_carry=4'h1, dbg_ha2_carry=4'h2, dbg_carry_chain=4'h3, Sum=4'h4, Cout=0.
